// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: req/ack data port with wait states and an optional timeout.
// Zero-wait and non-memory ops reach W in one cycle; each wait state adds one cycle while mem_stall freezes upstream.
module mem_wb_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] M_R,
    input  logic [31:0] M_R2,
    input  logic [31:0] M_pc_4,
    input  logic [4:0]  M_RW,
    input  logic        M_jal,
    input  logic        M_MemtoReg,
    input  logic        M_MemWrite,
    input  logic        M_sh,
    input  logic        M_RegWrite,
    input  logic        M_syscall,
    input  logic        M_mfc0,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_stall,
    output logic        mem_err,
    output logic [31:0] W_data,
    output logic [4:0]  W_RW,
    output logic        W_RegWrite,
    output logic        W_syscall,
    output logic [31:0] W_pc_4
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_mem;
    logic             mis;
    logic             tmo;
    logic             fail;
    logic [31:0]      wb_data;

    always_comb begin
        is_mem  = M_MemtoReg | M_MemWrite;
        mis     = is_mem & (M_sh ? M_R[0] : |M_R[1:0]);
        tmo     = (state == BUSY) && (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));
        // Gated by rst_n so the port goes quiet the instant reset asserts.
        dm_req  = rst_n & ((state == BUSY) | ((state == IDLE) & is_mem & ~mis));
        mem_stall = dm_req & ~dm_ack & ~tmo;
        // An ack arriving on the timeout cycle still counts as success.
        fail    = ((state == IDLE) & mis) | (tmo & ~dm_ack);
        dm_we   = M_MemWrite;
        dm_addr = {M_R[31:2], 2'b00};
        if (M_MemWrite && M_sh) begin
            dm_be = M_R[1] ? 4'b1100 : 4'b0011;
        end else begin
            dm_be = 4'b1111;
        end
        dm_wdata = M_sh ? {M_R2[15:0], M_R2[15:0]} : M_R2;
        if (M_jal) begin
            wb_data = M_pc_4;
        end else if (M_MemtoReg) begin
            wb_data = dm_rdata;
        end else begin
            wb_data = M_R;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_err    <= 1'b0;
            W_data     <= '0;
            W_RW       <= '0;
            W_pc_4     <= '0;
            W_RegWrite <= 1'b0;
            W_syscall  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dm_req && !dm_ack) begin
                        state <= BUSY;
                        cnt   <= CNT_W'(1);
                    end
                end
                BUSY: begin
                    if (dm_ack || tmo) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
            mem_err <= fail;
            // A stalled cycle writes a bubble so the held instruction retires exactly once.
            if (mem_stall) begin
                W_RegWrite <= 1'b0;
                W_syscall  <= 1'b0;
            end else begin
                W_data     <= wb_data;
                W_RW       <= M_RW;
                W_pc_4     <= M_pc_4;
                W_RegWrite <= M_RegWrite & ~fail;
                W_syscall  <= M_syscall;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a short timeout so the abort path is reachable.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] M_R, M_R2, M_pc_4;
    logic [4:0]  M_RW;
    logic        M_jal, M_MemtoReg, M_MemWrite, M_sh, M_RegWrite, M_syscall, M_mfc0;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_stall, mem_err;
    logic [31:0] W_data, W_pc_4;
    logic [4:0]  W_RW;
    logic        W_RegWrite, W_syscall;

    int checks = 0;
    int errors = 0;
    int sys_cnt;

    mem_wb_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .M_R(M_R), .M_R2(M_R2), .M_pc_4(M_pc_4), .M_RW(M_RW),
        .M_jal(M_jal), .M_MemtoReg(M_MemtoReg), .M_MemWrite(M_MemWrite), .M_sh(M_sh),
        .M_RegWrite(M_RegWrite), .M_syscall(M_syscall), .M_mfc0(M_mfc0),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_stall(mem_stall), .mem_err(mem_err),
        .W_data(W_data), .W_RW(W_RW), .W_RegWrite(W_RegWrite), .W_syscall(W_syscall), .W_pc_4(W_pc_4)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_m();
        M_R = '0; M_R2 = '0; M_pc_4 = '0; M_RW = '0;
        M_jal = 0; M_MemtoReg = 0; M_MemWrite = 0; M_sh = 0;
        M_RegWrite = 0; M_syscall = 0; M_mfc0 = 0;
        dm_ack = 0; dm_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_m();
        rst_n = 1'b0;
        #3;
        check_eq("rst_W_data", W_data, 32'h0);
        check_eq("rst_W_RW", W_RW, 32'h0);
        check_eq("rst_W_RegWrite", W_RegWrite, 32'h0);
        check_eq("rst_W_syscall", W_syscall, 32'h0);
        check_eq("rst_mem_err", mem_err, 32'h0);
        check_eq("rst_dm_req", dm_req, 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Non-memory ALU op
        M_R = 32'h1234; M_RegWrite = 1; M_RW = 5'd8;
        #1;
        check_eq("alu_dm_req", dm_req, 32'h0);
        check_eq("alu_stall", mem_stall, 32'h0);
        tick();
        check_eq("alu_W_data", W_data, 32'h1234);
        check_eq("alu_W_RW", W_RW, 32'd8);
        check_eq("alu_W_RegWrite", W_RegWrite, 32'h1);
        clear_m();

        // Zero-wait load
        M_MemtoReg = 1; M_R = 32'h100; M_RegWrite = 1; M_RW = 5'd5;
        dm_ack = 1; dm_rdata = 32'hDEADBEEF;
        #1;
        check_eq("zw_dm_req", dm_req, 32'h1);
        check_eq("zw_dm_addr", dm_addr, 32'h100);
        check_eq("zw_dm_be", dm_be, 32'hF);
        check_eq("zw_dm_we", dm_we, 32'h0);
        check_eq("zw_stall", mem_stall, 32'h0);
        tick();
        check_eq("zw_W_data", W_data, 32'hDEADBEEF);
        check_eq("zw_W_RegWrite", W_RegWrite, 32'h1);
        clear_m();

        // sh to upper halfword, ack on the fourth cycle
        M_sh = 1; M_MemWrite = 1; M_R = 32'h202; M_R2 = 32'hAAAA5555;
        #1;
        check_eq("sh_dm_be", dm_be, 32'hC);
        check_eq("sh_dm_wdata", dm_wdata, 32'h55555555);
        check_eq("sh_dm_we", dm_we, 32'h1);
        check_eq("sh_dm_addr", dm_addr, 32'h200);
        for (int i = 1; i <= 4; i++) begin
            dm_ack = (i == 4);
            #1;
            check_eq($sformatf("sh_stall_%0d", i), mem_stall, (i < 4) ? 32'h1 : 32'h0);
            check_eq($sformatf("sh_req_%0d", i), dm_req, 32'h1);
            tick();
            check_eq($sformatf("sh_W_RegWrite_%0d", i), W_RegWrite, 32'h0);
            check_eq($sformatf("sh_mem_err_%0d", i), mem_err, 32'h0);
        end
        clear_m();
        #1;
        check_eq("sh_done_req", dm_req, 32'h0);

        // Misaligned word load, then misaligned sh
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                M_MemtoReg = 1; M_R = 32'h101;
            end else begin
                M_MemWrite = 1; M_sh = 1; M_R = 32'h201;
            end
            M_RegWrite = 1; M_RW = 5'd3;
            #1;
            check_eq($sformatf("mis%0d_dm_req", k), dm_req, 32'h0);
            check_eq($sformatf("mis%0d_stall", k), mem_stall, 32'h0);
            tick();
            check_eq($sformatf("mis%0d_mem_err", k), mem_err, 32'h1);
            check_eq($sformatf("mis%0d_W_RegWrite", k), W_RegWrite, 32'h0);
            clear_m();
            tick();
            check_eq($sformatf("mis%0d_err_pulse", k), mem_err, 32'h0);
        end

        // Timeout with no ack (k=0), then ack exactly at counter==TIMEOUT (k=1)
        for (int k = 0; k < 2; k++) begin
            M_MemtoReg = 1; M_R = 32'h200; M_RegWrite = 1; M_RW = 5'd9;
            dm_rdata = 32'h600DF00D;
            for (int i = 1; i <= 5; i++) begin
                dm_ack = (k == 1) && (i == 5);
                #1;
                check_eq($sformatf("to%0d_stall_%0d", k, i), mem_stall, (i <= 4) ? 32'h1 : 32'h0);
                tick();
                if (i < 5) begin
                    check_eq($sformatf("to%0d_err_%0d", k, i), mem_err, 32'h0);
                end
            end
            check_eq($sformatf("to%0d_mem_err", k), mem_err, (k == 0) ? 32'h1 : 32'h0);
            check_eq($sformatf("to%0d_W_RegWrite", k), W_RegWrite, (k == 0) ? 32'h0 : 32'h1);
            if (k == 1) check_eq("to1_W_data", W_data, 32'h600DF00D);
            clear_m();
            tick();
            check_eq($sformatf("to%0d_err_after", k), mem_err, 32'h0);
        end

        // jal writes PC+4
        M_jal = 1; M_pc_4 = 32'h3004; M_R = 32'h55; M_RegWrite = 1; M_RW = 5'd31;
        tick();
        check_eq("jal_W_data", W_data, 32'h3004);
        check_eq("jal_W_RW", W_RW, 32'd31);
        check_eq("jal_W_pc_4", W_pc_4, 32'h3004);
        clear_m();

        // syscall held through two stall cycles must retire once
        sys_cnt = 0;
        M_syscall = 1; M_MemtoReg = 1; M_R = 32'h300;
        for (int i = 1; i <= 3; i++) begin
            dm_ack = (i == 3);
            tick();
            if (W_syscall) sys_cnt++;
        end
        check_eq("sys_W_syscall", W_syscall, 32'h1);
        clear_m();
        tick();
        if (W_syscall) sys_cnt++;
        tick();
        if (W_syscall) sys_cnt++;
        check_eq("sys_count", sys_cnt, 32'd1);

        // Reset while BUSY
        M_MemtoReg = 1; M_R = 32'h400; M_RegWrite = 1; M_RW = 5'd7; M_pc_4 = 32'h44;
        tick();
        check_eq("rb_stall_before", mem_stall, 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rb_dm_req", dm_req, 32'h0);
        check_eq("rb_stall", mem_stall, 32'h0);
        check_eq("rb_W_data", W_data, 32'h0);
        check_eq("rb_W_pc_4", W_pc_4, 32'h0);
        check_eq("rb_W_RegWrite", W_RegWrite, 32'h0);
        check_eq("rb_mem_err", mem_err, 32'h0);
        tick();
        clear_m();
        rst_n = 1'b1;
        tick();
        check_eq("rb_err_after", mem_err, 32'h0);
        check_eq("rb_req_after", dm_req, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
